upsp_output_merger: RTL and testbench

Parametrised write-back merger sitting between N_PARALLEL bicubic processing elements and the access-control output AXI-Stream. Each PE owns one vertical column segment of the destination image. The block buffers each PE's write stream in a per-lane FIFO and re-serialises the lanes into raster order, lane 0 through the last active lane per row. It marks row ends with tlast and frame start with tuser, and supports a run-time active-lane count.

---
 rtl/upsp_pkg.sv | 20 ++
 rtl/merger_lane_fifo.sv | 47 ++++
 rtl/upsp_output_merger.sv | 185 ++++++++++++++++++
 tb/tb_upsp_output_merger.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsp_pkg.sv
// Shared types and constants for the upsampler write-back path (PE array, merger, access control).
package upsp_pkg;

  localparam int UPSP_N_PARALLEL = 4;
  localparam int UPSP_DATA_WIDTH = 96;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } merger_state_t;

  // A zero or out-of-range config field falls back to dflt.
  function automatic logic [31:0] norm_cfg(input logic [31:0] value,
                                           input logic [31:0] dflt,
                                           input logic [31:0] max_val);
    norm_cfg = ((value == 32'd0) || (value > max_val)) ? dflt : value;
  endfunction

endpackage

// File: rtl/merger_lane_fifo.sv
// Per-lane show-ahead FIFO: the head entry is always visible on rd_data while !empty.
module merger_lane_fifo #(
  parameter int DATA_WIDTH = 96,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_write;
  logic                  do_read;

  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;

  // The extra pointer MSB separates full (wrap bits differ) from empty (identical pointers).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/upsp_output_merger.sv
// Merges per-PE column-segment write streams back into one raster-ordered AXI-Stream.
module upsp_output_merger
  import upsp_pkg::*;
#(
  parameter int N_PARALLEL  = UPSP_N_PARALLEL,
  parameter int DATA_WIDTH  = UPSP_DATA_WIDTH,
  parameter int SEG_BEATS_W = 16,
  parameter int ROWS_W      = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(N_PARALLEL+1)-1:0]  cfg_n_active,
  input  logic [SEG_BEATS_W-1:0]           cfg_seg_beats,
  input  logic [ROWS_W-1:0]                cfg_rows,
  output logic                             busy,
  output logic                             done,
  input  logic [N_PARALLEL-1:0]            upsp_ac_wvalid,
  input  logic [N_PARALLEL*DATA_WIDTH-1:0] upsp_ac_wdata,
  output logic [N_PARALLEL-1:0]            ac_upsp_wready,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser
);

  localparam int LANE_W = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;

  merger_state_t state;
  merger_state_t next_state;

  logic [N_PARALLEL-1:0]            lane_en;
  logic [N_PARALLEL-1:0]            fifo_full;
  logic [N_PARALLEL-1:0]            fifo_empty;
  logic [N_PARALLEL-1:0]            fifo_wr;
  logic [N_PARALLEL-1:0]            fifo_rd;
  logic [N_PARALLEL*DATA_WIDTH-1:0] fifo_dout;

  logic [LANE_W-1:0]      lane;
  logic [LANE_W-1:0]      last_lane;
  logic [SEG_BEATS_W-1:0] beat;
  logic [SEG_BEATS_W-1:0] last_beat;
  logic [ROWS_W-1:0]      row;
  logic [ROWS_W-1:0]      last_row;
  logic                   all_loaded;

  logic [31:0] n_norm;
  logic [31:0] seg_norm;
  logic [31:0] rows_norm;

  logic                  accept_start;
  logic                  load;
  logic                  out_fire;
  logic                  seg_end;
  logic                  lane_end;
  logic                  row_end;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_empty;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_user;
  logic                  out_final;

  assign accept_start = (state == IDLE) && start;

  assign n_norm    = norm_cfg(32'(cfg_n_active), 32'(N_PARALLEL), 32'(N_PARALLEL));
  assign seg_norm  = norm_cfg(32'(cfg_seg_beats), 32'd1, 32'hFFFF_FFFF);
  assign rows_norm = norm_cfg(32'(cfg_rows), 32'd1, 32'hFFFF_FFFF);

  assign head_data  = fifo_dout[lane*DATA_WIDTH +: DATA_WIDTH];
  assign head_empty = fifo_empty[lane];

  assign seg_end  = (beat == last_beat);
  assign lane_end = (lane == last_lane);
  assign row_end  = (row == last_row);

  // Once the frame's final beat is in the output register, surplus FIFO contents are left alone.
  assign load     = (state == RUN) && !all_loaded && !head_empty && (!out_valid || m_axis_tready);
  assign out_fire = out_valid && m_axis_tready;

  for (genvar i = 0; i < N_PARALLEL; i++) begin : g_lane
    assign ac_upsp_wready[i] = (state == RUN) && lane_en[i] && !fifo_full[i];
    assign fifo_wr[i]        = upsp_ac_wvalid[i] && ac_upsp_wready[i];
    assign fifo_rd[i]        = load && (lane == LANE_W'(i));

    merger_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (accept_start),
      .wr_en   (fifo_wr[i]),
      .wr_data (upsp_ac_wdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en   (fifo_rd[i]),
      .rd_data (fifo_dout[i*DATA_WIDTH +: DATA_WIDTH]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (out_fire && out_final) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_en    <= '0;
      last_lane  <= '0;
      last_beat  <= '0;
      last_row   <= '0;
      lane       <= '0;
      beat       <= '0;
      row        <= '0;
      all_loaded <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_user   <= 1'b0;
      out_final  <= 1'b0;
    end else begin
      if (accept_start) begin
        for (int i = 0; i < N_PARALLEL; i++) lane_en[i] <= (32'(i) < n_norm);
        last_lane  <= LANE_W'(n_norm - 32'd1);
        last_beat  <= SEG_BEATS_W'(seg_norm - 32'd1);
        last_row   <= ROWS_W'(rows_norm - 32'd1);
        lane       <= '0;
        beat       <= '0;
        row        <= '0;
        all_loaded <= 1'b0;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head_data;
        out_last  <= lane_end && seg_end;
        out_user  <= (row == '0) && (lane == '0) && (beat == '0);
        out_final <= lane_end && seg_end && row_end;
        if (lane_end && seg_end && row_end) all_loaded <= 1'b1;
        if (seg_end) begin
          beat <= '0;
          if (lane_end) begin
            lane <= '0;
            row  <= row + 1'b1;
          end else begin
            lane <= lane + 1'b1;
          end
        end else begin
          beat <= beat + 1'b1;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = out_user;

endmodule

// File: tb/tb_upsp_output_merger.sv
// Self-checking bench for upsp_output_merger: table of frame configs plus random frames vs a raster model.
module tb_upsp_output_merger;

  localparam int N     = 4;
  localparam int DW    = 96;
  localparam int SW    = 16;
  localparam int RW    = 16;
  localparam int DEPTH = 8;
  localparam int NAW   = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NAW-1:0]    cfg_n_active;
  logic [SW-1:0]     cfg_seg_beats;
  logic [RW-1:0]     cfg_rows;
  logic              busy;
  logic              done;
  logic [N-1:0]      upsp_ac_wvalid;
  logic [N*DW-1:0]   upsp_ac_wdata;
  logic [N-1:0]      ac_upsp_wready;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tuser;

  always #5 clk = ~clk;

  upsp_output_merger #(
    .N_PARALLEL  (N),
    .DATA_WIDTH  (DW),
    .SEG_BEATS_W (SW),
    .ROWS_W      (RW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_n_active   (cfg_n_active),
    .cfg_seg_beats  (cfg_seg_beats),
    .cfg_rows       (cfg_rows),
    .busy           (busy),
    .done           (done),
    .upsp_ac_wvalid (upsp_ac_wvalid),
    .upsp_ac_wdata  (upsp_ac_wdata),
    .ac_upsp_wready (ac_upsp_wready),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  // fill_mode 0: lane*16+idx, 1: random. order_mode 1: lane 3 alone first.
  typedef struct {
    int n_cfg;
    int seg_cfg;
    int rows_cfg;
    int ready_pct;
    int valid_pct;
    int fill_mode;
    int order_mode;
    int abort_after;
    int restart_mid;
    int exp_beats;
    int exp_lasts;
    int expect_full;
  } vec_t;

  int checks = 0;
  int errors = 0;

  beat_t         got_q[$];
  beat_t         exp_q[$];
  logic [DW-1:0] lane_data [N][64];
  int            sent [N];
  int            na, seg, rows, quota;
  int            cur_valid_pct, cur_ready_pct;
  logic [N-1:0]  allow;
  logic [N-1:0]  active_mask;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic set_drive();
    for (int l = 0; l < N; l++) begin
      if (l < na && sent[l] < quota && allow[l] && ($urandom_range(99) < cur_valid_pct)) begin
        upsp_ac_wvalid[l]          = 1'b1;
        upsp_ac_wdata[l*DW +: DW]  = lane_data[l][sent[l]];
      end else begin
        upsp_ac_wvalid[l] = 1'b0;
      end
    end
    m_axis_tready = ($urandom_range(99) < cur_ready_pct);
  endtask

  task automatic applyStimulus(input vec_t v);
    int     cyc, final_cyc, done_cyc, lasts, nbad_wready;
    bit     done_seen, done_busy, aborted, prev_stall;
    bit     full_seen [N];
    beat_t  prev_beat;
    beat_t  e;
    logic [N-1:0] hs_w;

    na   = (v.n_cfg == 0 || v.n_cfg > N) ? N : v.n_cfg;
    seg  = (v.seg_cfg == 0) ? 1 : v.seg_cfg;
    rows = (v.rows_cfg == 0) ? 1 : v.rows_cfg;
    quota = seg * rows;
    cur_valid_pct = v.valid_pct;
    cur_ready_pct = v.ready_pct;
    active_mask = '0;
    for (int l = 0; l < N; l++) begin
      if (l < na) active_mask[l] = 1'b1;
      sent[l] = 0;
      full_seen[l] = 1'b0;
      for (int k = 0; k < quota; k++)
        lane_data[l][k] = (v.fill_mode == 0) ? DW'(l * 16 + k) : {$urandom(), $urandom(), $urandom()};
    end
    allow = (v.order_mode == 1) ? 4'b1000 : '1;

    exp_q.delete();
    for (int r = 0; r < rows; r++)
      for (int l = 0; l < na; l++)
        for (int b = 0; b < seg; b++) begin
          e.data = lane_data[l][r * seg + b];
          e.last = (l == na - 1) && (b == seg - 1);
          e.user = (r == 0) && (l == 0) && (b == 0);
          exp_q.push_back(e);
        end
    got_q.delete();

    @(posedge clk); #1;
    cfg_n_active  = NAW'(v.n_cfg);
    cfg_seg_beats = SW'(v.seg_cfg);
    cfg_rows      = RW'(v.rows_cfg);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", DW'(busy), DW'(1));
    checkOutput("wready_after_start", DW'(ac_upsp_wready), DW'(active_mask));
    set_drive();

    cyc = 0; final_cyc = -10; done_cyc = -20; nbad_wready = 0;
    done_seen = 0; done_busy = 0; aborted = 0; prev_stall = 0;
    prev_beat = '{default: '0};
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        checkOutput("hold_valid", DW'(m_axis_tvalid), DW'(1));
        checkOutput("hold_data", m_axis_tdata, prev_beat.data);
        checkOutput("hold_flags", DW'({m_axis_tlast, m_axis_tuser}), DW'({prev_beat.last, prev_beat.user}));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat.data = m_axis_tdata;
      prev_beat.last = m_axis_tlast;
      prev_beat.user = m_axis_tuser;
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(prev_beat);
        if (got_q.size() == exp_q.size()) final_cyc = cyc;
      end
      if (done) begin
        done_seen = 1; done_cyc = cyc; done_busy = busy;
      end
      if ((ac_upsp_wready & ~active_mask) != '0) nbad_wready++;
      for (int l = 0; l < N; l++)
        if (busy && upsp_ac_wvalid[l] && !ac_upsp_wready[l]) full_seen[l] = 1'b1;
      hs_w = upsp_ac_wvalid & ac_upsp_wready;
      if (done_seen) break;

      @(posedge clk); #1;
      for (int l = 0; l < N; l++) if (hs_w[l]) sent[l]++;
      if (v.restart_mid != 0) begin
        start = (it == 2);
        if (it == 2) cfg_n_active = NAW'(1);
      end
      if (v.order_mode == 1 && it == 20) begin
        checkOutput("ooo_lane3_writes", DW'(sent[3]), DW'(DEPTH));
        checkOutput("ooo_no_output", DW'(got_q.size()), DW'(0));
        checkOutput("ooo_lane3_wready", DW'(ac_upsp_wready[3]), DW'(0));
        allow = '1;
      end
      if (v.abort_after > 0 && got_q.size() >= v.abort_after) begin
        aborted = 1;
        break;
      end
      set_drive();
    end

    if (aborted) begin
      rst = 1'b1;
      upsp_ac_wvalid = '0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_tvalid", DW'(m_axis_tvalid), DW'(0));
      checkOutput("abort_busy", DW'(busy), DW'(0));
      checkOutput("abort_wready", DW'(ac_upsp_wready), DW'(0));
      rst = 1'b0;
      return;
    end

    checks++;
    if (!done_seen) begin
      errors++;
      $display("[TB] FAIL frame_timeout: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    upsp_ac_wvalid = '0;

    checkOutput("beat_count", DW'(got_q.size()), DW'(exp_q.size()));
    lasts = 0;
    foreach (got_q[k]) if (got_q[k].last) lasts++;
    if (v.exp_beats >= 0) begin
      checkOutput("table_beats", DW'(got_q.size()), DW'(v.exp_beats));
      checkOutput("table_lasts", DW'(lasts), DW'(v.exp_lasts));
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checkOutput($sformatf("beat%0d_data", k), got_q[k].data, exp_q[k].data);
      checkOutput($sformatf("beat%0d_last_user", k), DW'({got_q[k].last, got_q[k].user}),
                  DW'({exp_q[k].last, exp_q[k].user}));
    end
    checkOutput("done_delay", DW'(done_cyc), DW'(final_cyc + 1));
    checkOutput("busy_low_with_done", DW'(done_busy), DW'(0));
    checkOutput("inactive_wready", DW'(nbad_wready), DW'(0));
    if (v.expect_full != 0)
      for (int l = 0; l < na; l++)
        checkOutput($sformatf("lane%0d_full_stall", l), DW'(full_seen[l]), DW'(1));

    @(negedge clk);
    checkOutput("done_one_cycle", DW'({done, busy}), DW'(0));
    checkOutput("idle_wready", DW'(ac_upsp_wready), DW'(0));
  endtask

  vec_t vecs [7];
  vec_t rv;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_n_active = '0;
    cfg_seg_beats = '0;
    cfg_rows = '0;
    upsp_ac_wvalid = '0;
    upsp_ac_wdata = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tvalid", DW'(m_axis_tvalid), DW'(0));
    checkOutput("reset_tdata", m_axis_tdata, DW'(0));
    checkOutput("reset_flags", DW'({m_axis_tlast, m_axis_tuser}), DW'(0));
    checkOutput("reset_busy_done", DW'({busy, done}), DW'(0));
    checkOutput("reset_wready", DW'(ac_upsp_wready), DW'(0));
    rst = 1'b0;

    //          n  seg rows rdy vld fill ord abort rst beats lasts full
    vecs[0] = '{4, 3,  2,   100, 100, 0, 0, 0, 0, 24, 2, 0};
    vecs[1] = '{2, 2,  1,   100, 100, 0, 0, 0, 0,  4, 1, 0};
    vecs[2] = '{4, 4,  4,    30, 100, 1, 0, 0, 0, 64, 4, 1};
    vecs[3] = '{4, 10, 1,   100, 100, 0, 1, 0, 0, 40, 1, 0};
    vecs[4] = '{4, 3,  2,   100, 100, 0, 0, 5, 0, -1, 0, 0};
    vecs[5] = '{4, 3,  2,   100, 100, 1, 0, 0, 0, 24, 2, 0};
    vecs[6] = '{0, 0,  0,    50, 100, 1, 0, 0, 1,  4, 1, 0};
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.n_cfg       = $urandom_range(7);
      rv.seg_cfg     = $urandom_range(5);
      rv.rows_cfg    = $urandom_range(3);
      rv.ready_pct   = $urandom_range(100, 20);
      rv.valid_pct   = $urandom_range(100, 30);
      rv.fill_mode   = 1;
      rv.order_mode  = 0;
      rv.abort_after = 0;
      rv.restart_mid = 0;
      rv.exp_beats   = -1;
      rv.exp_lasts   = 0;
      rv.expect_full = 0;
      applyStimulus(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
